// File: rtl/pc_unit_gen_if.sv
// Fetch-PC control/status bundle between the F-stage steering logic and pc_unit_gen.
// The master side drives selects and redirect sources; the slave side returns the fetch PC and flags.
interface pc_unit_gen_if #(
    parameter int ADDR_W = 32
);
    logic [2:0]        pc_sel;
    logic              stall;
    logic [ADDR_W-1:0] d_pc;
    logic [25:0]       d_instr_index;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] jr_target;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc;
    logic              redirect_pending;
    logic              addr_err;

    modport master (
        output pc_sel, stall, d_pc, d_instr_index, branch_off, jr_target,
               exc_req, eret_req, epc,
        input  pc, redirect_pending, addr_err
    );

    modport slave (
        input  pc_sel, stall, d_pc, d_instr_index, branch_off, jr_target,
               exc_req, eret_req, epc,
        output pc, redirect_pending, addr_err
    );
endinterface

// File: rtl/pc_unit_gen.sv
// Fetch program counter with exception/ERET redirection, stall-buffered redirects and fetch address checking.
// Optional macro PC_REDIRECT_CNT_EN adds a 32-bit count of non-sequential PC loads on redirect_cnt.
module pc_unit_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6FFF
) (
    input  logic          clk,
    input  logic          reset,
`ifdef PC_REDIRECT_CNT_EN
    output logic [31:0]   redirect_cnt,
`endif
    pc_unit_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'b000,
        SEL_BRANCH = 3'b001,
        SEL_JUMP   = 3'b010,
        SEL_JR     = 3'b011,
        SEL_HOLD   = 3'b100
    } pc_sel_e;

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_reg;
    logic              pending_reg;
    logic [ADDR_W-1:0] pending_target;
    logic              addr_err_reg;

    logic [ADDR_W-1:0] seq_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] redirect_target;
    logic              is_redirect;

    logic [ADDR_W-1:0] next_pc;
    logic              next_pending;
    logic [ADDR_W-1:0] next_target;
    logic              next_addr_err;
    logic              load_nonseq;
    logic [31:0]       next_pc_ext;

    assign seq_target    = pc_reg + FOUR;
    assign branch_target = bus.d_pc + FOUR + bus.branch_off;

    // Narrowest legal PC has no region bits above the 28-bit jump field.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_target = {bus.d_pc[ADDR_W-1:28], bus.d_instr_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {bus.d_instr_index, 2'b00};
        end
    endgenerate

    always_comb begin
        redirect_target = '0;
        is_redirect     = 1'b0;
        case (pc_sel_e'(bus.pc_sel))
            SEL_BRANCH: begin redirect_target = branch_target;  is_redirect = 1'b1; end
            SEL_JUMP:   begin redirect_target = jump_target;    is_redirect = 1'b1; end
            SEL_JR:     begin redirect_target = bus.jr_target;  is_redirect = 1'b1; end
            default:    begin redirect_target = '0;             is_redirect = 1'b0; end
        endcase
    end

    // Exception and ERET override stall; otherwise a pending redirect beats the current select.
    always_comb begin
        next_pc      = pc_reg;
        next_pending = pending_reg;
        next_target  = pending_target;
        load_nonseq  = 1'b0;
        if (bus.exc_req) begin
            next_pc      = EXC_PC;
            next_pending = 1'b0;
            next_target  = '0;
            load_nonseq  = 1'b1;
        end else if (bus.eret_req) begin
            next_pc      = bus.epc;
            next_pending = 1'b0;
            next_target  = '0;
            load_nonseq  = 1'b1;
        end else if (bus.stall) begin
            if (is_redirect) begin
                next_pending = 1'b1;
                next_target  = redirect_target;
            end
        end else if (pending_reg) begin
            next_pc      = pending_target;
            next_pending = 1'b0;
            load_nonseq  = 1'b1;
        end else if (is_redirect) begin
            next_pc     = redirect_target;
            load_nonseq = 1'b1;
        end else if (pc_sel_e'(bus.pc_sel) == SEL_SEQ) begin
            next_pc = seq_target;
        end
    end

    always_comb begin
        next_pc_ext   = 32'(next_pc);
        next_addr_err = (next_pc[1:0] != 2'b00) ||
                        (next_pc_ext < TEXT_LO) ||
                        (next_pc_ext > TEXT_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            pending_reg    <= 1'b0;
            pending_target <= '0;
            addr_err_reg   <= 1'b0;
        end else begin
            pc_reg         <= next_pc;
            pending_reg    <= next_pending;
            pending_target <= next_target;
            addr_err_reg   <= next_addr_err;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt <= '0;
        end else if (load_nonseq) begin
            redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

    assign bus.pc               = pc_reg;
    assign bus.redirect_pending = pending_reg;
    assign bus.addr_err         = addr_err_reg;

endmodule
